// File: rtl/rs232_out_serializer_cfg_if.sv
// Bus-side write port of the configurable RS232 transmitter: queue strobe, data word
// and the FIFO status fed back to the register block.
interface rs232_out_serializer_cfg_if #(
   parameter int MAX_DATA_WIDTH = 9,
   parameter int ADDR_WIDTH     = 7
);
   logic [MAX_DATA_WIDTH-1:0] transmit_data;
   logic                      transmit_data_en;
   logic [ADDR_WIDTH:0]       fifo_write_space;
   logic                      write_overflow;

   modport master (
      output transmit_data,
      output transmit_data_en,
      input  fifo_write_space,
      input  write_overflow
   );

   modport slave (
      input  transmit_data,
      input  transmit_data_en,
      output fifo_write_space,
      output write_overflow
   );
endinterface

// File: rtl/rs232_out_serializer_cfg.sv
// Runtime-configurable RS232 transmitter: FIFO-buffered words framed with start bit,
// 5..9 data bits, optional parity and 1/2 stop bits, gated by CTS.
module rs232_out_serializer_cfg #(
   parameter int MAX_DATA_WIDTH     = 9,
   parameter int FIFO_DEPTH         = 128,
   parameter int ADDR_WIDTH         = 7,
   parameter int BAUD_COUNTER_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   rs232_out_serializer_cfg_if.slave     bus,
   input  logic [3:0]                    cfg_data_bits,
   input  logic [2:0]                    cfg_parity,
   input  logic                          cfg_two_stop,
   input  logic [BAUD_COUNTER_WIDTH-1:0] cfg_baud_divisor,
   input  logic                          cts_n,
   output logic                          tx_busy,
   output logic                          serial_data_out
);
   localparam logic [ADDR_WIDTH:0]         DEPTH_C    = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH:0]         CNT_ZERO_C = '0;
   localparam logic [BAUD_COUNTER_WIDTH-1:0] BAUD_ONE_C = BAUD_COUNTER_WIDTH'(1);
   localparam logic [BAUD_COUNTER_WIDTH-1:0] BAUD_TWO_C = BAUD_COUNTER_WIDTH'(2);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   logic [MAX_DATA_WIDTH-1:0]     mem_r [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]         wr_ptr_r, rd_ptr_r;
   logic [ADDR_WIDTH:0]           count_r;
   logic                          empty_r, idle_q_r;
   state_t                        state_r, state_s;
   logic [MAX_DATA_WIDTH-1:0]     shift_r;
   logic [3:0]                    bits_r, bit_idx_r;
   logic [2:0]                    par_mode_r;
   logic                          two_stop_r, stop_idx_r, par_acc_r;
   logic [BAUD_COUNTER_WIDTH-1:0] div_r, baud_cnt_r;
   logic                          full_s, wr_ok_s, pop_s, bit_done_s;
   logic                          line_s, busy_s, par_bit_s;

   // Full is judged on the pre-read count, so a write while full is always dropped.
   // The empty flag and the one-cycle IDLE dwell give the fixed W+3 start latency
   // and the two idle clocks between back-to-back frames.
   assign full_s     = (count_r == DEPTH_C);
   assign wr_ok_s    = bus.transmit_data_en & ~full_s;
   assign pop_s      = (state_r == S_IDLE) & idle_q_r & ~empty_r & ~cts_n;
   assign bit_done_s = (baud_cnt_r == (div_r - BAUD_ONE_C));

   // FIFO storage; stale entries are harmless because reset clears the pointers.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_r[wr_ptr_r] <= bus.transmit_data;
      end
   end

   // FIFO pointers, occupancy and lagged empty flag.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         empty_r  <= 1'b1;
      end else begin
         wr_ptr_r <= wr_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, wr_ok_s};
         rd_ptr_r <= rd_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, pop_s};
         count_r  <= count_r + {CNT_ZERO_C[ADDR_WIDTH:1], wr_ok_s}
                             - {CNT_ZERO_C[ADDR_WIDTH:1], pop_s};
         empty_r  <= (count_r == CNT_ZERO_C);
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r  <= S_IDLE;
         idle_q_r <= 1'b1;
      end else begin
         state_r  <= state_s;
         idle_q_r <= (state_r == S_IDLE);
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE:   if (pop_s) state_s = S_START; else state_s = S_IDLE;
         S_START:  if (bit_done_s) state_s = S_DATA; else state_s = S_START;
         S_DATA: begin
            if (bit_done_s && (bit_idx_r == (bits_r - 4'd1))) begin
               if (par_mode_r != 3'd0) state_s = S_PARITY; else state_s = S_STOP;
            end else begin
               state_s = S_DATA;
            end
         end
         S_PARITY: if (bit_done_s) state_s = S_STOP; else state_s = S_PARITY;
         S_STOP: begin
            if (bit_done_s && (!two_stop_r || stop_idx_r)) state_s = S_IDLE;
            else state_s = S_STOP;
         end
         default:  state_s = S_IDLE;
      endcase
   end

   // FSM output logic: line level and busy before the output register.
   always_comb begin
      line_s = 1'b1;
      busy_s = 1'b1;
      case (par_mode_r)
         3'd1:    par_bit_s = par_acc_r;
         3'd2:    par_bit_s = ~par_acc_r;
         3'd3:    par_bit_s = 1'b1;
         default: par_bit_s = 1'b0;
      endcase
      case (state_r)
         S_IDLE:   begin line_s = 1'b1; busy_s = 1'b0; end
         S_START:  line_s = 1'b0;
         S_DATA:   line_s = shift_r[0];
         S_PARITY: line_s = par_bit_s;
         S_STOP:   line_s = 1'b1;
         default:  begin line_s = 1'b1; busy_s = 1'b0; end
      endcase
   end

   // Frame datapath: configuration is latched on the pop, so mid-frame changes wait.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shift_r    <= '0;
         bits_r     <= 4'd8;
         bit_idx_r  <= 4'd0;
         par_mode_r <= 3'd0;
         two_stop_r <= 1'b0;
         stop_idx_r <= 1'b0;
         par_acc_r  <= 1'b0;
         div_r      <= BAUD_TWO_C;
         baud_cnt_r <= '0;
      end else if (pop_s) begin
         shift_r    <= mem_r[rd_ptr_r];
         bits_r     <= (cfg_data_bits < 4'd5) ? 4'd5 :
                       ((cfg_data_bits > 4'd9) ? 4'd9 : cfg_data_bits);
         par_mode_r <= (cfg_parity > 3'd4) ? 3'd0 : cfg_parity;
         two_stop_r <= cfg_two_stop;
         div_r      <= (cfg_baud_divisor < BAUD_TWO_C) ? BAUD_TWO_C : cfg_baud_divisor;
         bit_idx_r  <= 4'd0;
         stop_idx_r <= 1'b0;
         par_acc_r  <= 1'b0;
         baud_cnt_r <= '0;
      end else if (state_r == S_IDLE) begin
         baud_cnt_r <= '0;
      end else if (bit_done_s) begin
         baud_cnt_r <= '0;
         if (state_r == S_DATA) begin
            shift_r   <= shift_r >> 1;
            bit_idx_r <= bit_idx_r + 4'd1;
            par_acc_r <= par_acc_r ^ shift_r[0];
         end
         if (state_r == S_STOP) begin
            stop_idx_r <= 1'b1;
         end
      end else begin
         baud_cnt_r <= baud_cnt_r + BAUD_ONE_C;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         serial_data_out      <= 1'b1;
         tx_busy              <= 1'b0;
         bus.fifo_write_space <= '0;
         bus.write_overflow   <= 1'b0;
      end else begin
         serial_data_out      <= line_s;
         tx_busy              <= busy_s;
         bus.fifo_write_space <= DEPTH_C - count_r;
         bus.write_overflow   <= bus.transmit_data_en & full_s;
      end
   end
endmodule

// File: doc/rs232_out_serializer_cfg.md
Name: rs232_out_serializer_cfg

Overview:
Runtime-configurable RS232 UART transmitter, successor to the fixed-format output serializer.
- Buffers words in an internal synchronous FIFO of parameterised depth.
- Frames each word with a start bit, 5–9 data bits (LSB first), optional parity and 1 or 2 stop bits, at a runtime baud divisor.
- Honours CTS hardware flow control.
- Sits between the bus-side RS232 register interface and the UART TXD pin.

Parameters:
- MAX_DATA_WIDTH, 9: width of the transmit_data port and FIFO word.
- FIFO_DEPTH, 128: FIFO words; power of two.
- ADDR_WIDTH, 7: log2(FIFO_DEPTH).
- BAUD_COUNTER_WIDTH, 16: width of the baud divisor and counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous reset, active-low.
- transmit_data  in  MAX_DATA_WIDTH  word to queue; bit 0 is sent first.
- transmit_data_en  in  1  write strobe; accepted when FIFO not full.
- cfg_data_bits  in  4  data bits per frame; legal 5..9, others clamped to that range.
- cfg_parity  in  3  0 none, 1 even, 2 odd, 3 mark (1), 4 space (0); 5–7 act as none.
- cfg_two_stop  in  1  0: one stop bit; 1: two stop bits.
- cfg_baud_divisor  in  BAUD_COUNTER_WIDTH  clocks per bit; values below 2 act as 2.
- cts_n  in  1  clear-to-send, active-low.
- fifo_write_space  out  ADDR_WIDTH+1  free FIFO words, registered.
- write_overflow  out  1  one-cycle pulse when a write is dropped.
- tx_busy  out  1  high while any frame bit is on the line.
- serial_data_out  out  1  TXD line; idle level 1.

Behaviour:
- Reset (reset_n=0 at a clk edge), applies at any time including mid-frame:
  - serial_data_out=1, tx_busy=0, write_overflow=0, fifo_write_space=0.
  - FIFO flushed; FSM to IDLE; partial frame abandoned.
  - First cycle after release: fifo_write_space=FIFO_DEPTH.
- FIFO write:
  - transmit_data_en=1 while full → word dropped, write_overflow=1 next cycle.
  - Write and read in the same cycle while full → the write is still dropped (full is evaluated before the read).
  - fifo_write_space = FIFO_DEPTH − words_used, registered with 1-cycle lag.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when FIFO not empty and cts_n=0: pop one word in that cycle.
  - On the pop, latch word, data_bits, parity, two_stop and divisor. Config changes mid-frame take effect on the next frame only.
  - START: line 0 for one bit period → DATA.
  - DATA: send latched bits [0..data_bits−1], one bit period each; upper word bits ignored. → PARITY if parity enabled, else STOP.
  - PARITY: even = XOR of sent data bits; odd = its inverse; mark = 1; space = 0. One bit period → STOP.
  - STOP: line 1 for 1 or 2 bit periods → IDLE.
- Bit period: exactly max(divisor,2) clocks per bit.
  - Baud counter reloads at each bit boundary.
  - Counter is held at 0 in IDLE.
- Latency:
  - Write accepted at edge W into an empty FIFO, idle FSM, cts_n=0 → serial_data_out falls at edge W+3.
  - Back-to-back frames: line high exactly 2 extra clocks after the last stop period before the next start bit.
- Registered outputs: serial_data_out is registered from the FSM/shift register, so the line never glitches.
- tx_busy: 1 from the edge serial_data_out falls for START to the end of the last stop period.
- CTS:
  - Sampled only in IDLE.
  - cts_n=1 holds words in the FIFO with the line at 1.
  - Deassertion mid-frame does not truncate the frame.
- Frame length = 1 + data_bits + (parity?1:0) + (two_stop?2:1) bit periods.

Test Plan:
1. 8N1, divisor 4, write 0x55 → line low at W+3, then bits 1,0,1,0,1,0,1,0, stop 1; total 40 clocks; tx_busy high for those 40 clocks.
2. 7E2, divisor 3, write 0x41 → data 1,0,0,0,0,0,1, parity 0, two stop bits; 11 bits = 33 clocks. 7O1 with the same word → parity 1.
3. Hold cts_n=1, write 129 words → fifo_write_space steps 128..0; 129th write gives write_overflow pulse; line stays 1. Release cts_n → 128 frames, each separated by exactly 2 idle clocks.
4. Change cfg_baud_divisor from 4 to 8 mid-frame → current frame stays at 4 clocks/bit; next frame uses 8 clocks/bit.
5. Assert reset_n=0 for one clock mid-DATA → serial_data_out=1 next cycle, fifo_write_space=0 during reset, then 128; no further frames.
6. 9-bit mark parity, write 0x1FF, divisor 1 (acts as 2) → 12 bits at 2 clocks/bit: start 0, nine 1s, parity 1, stop 1.
